// File: rtl/serial_frame_parity.sv
// Serial-to-parallel framer: packs FRAME_LEN serial bits (first bit in MSB),
// emits the frame with even/odd parity and a one-cycle valid, and counts frames.
module serial_frame_parity #(
  parameter int FRAME_LEN = 3,
  parameter bit ODD       = 1'b0,
  parameter int CNT_W     = 8,
  localparam int IDX_W    = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dat,
  input  logic                 dat_en,
  input  logic                 sync,
  output logic [FRAME_LEN-1:0] frame_out,
  output logic                 par_out,
  output logic                 out_vld,
  output logic [IDX_W-1:0]     bit_idx,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  // Only the FRAME_LEN-1 most recent bits are stored; the incoming bit
  // completes the word in sh_next.
  logic [FRAME_LEN-2:0] sh;
  logic                 acc;
  logic [FRAME_LEN-1:0] sh_next;

  assign sh_next = {sh, dat};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh        <= '0;
      acc       <= 1'b0;
      bit_idx   <= '0;
      frame_out <= '0;
      par_out   <= 1'b0;
      out_vld   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      out_vld <= 1'b0;
      if (sync) begin
        // A bit accepted with sync starts a new frame and never completes one.
        if (dat_en) begin
          sh      <= sh_next[FRAME_LEN-2:0];
          acc     <= dat;
          bit_idx <= IDX_W'(1);
        end else begin
          acc     <= 1'b0;
          bit_idx <= '0;
        end
      end else if (dat_en) begin
        sh <= sh_next[FRAME_LEN-2:0];
        if (bit_idx == LAST_IDX) begin
          frame_out <= sh_next;
          par_out   <= acc ^ dat ^ ODD;
          out_vld   <= 1'b1;
          frame_cnt <= frame_cnt + CNT_W'(1);
          bit_idx   <= '0;
          acc       <= 1'b0;
        end else begin
          acc     <= acc ^ dat;
          bit_idx <= bit_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_parity.sv
// Bench for serial_frame_parity: two instances (3-bit even / 8-bit odd) on shared
// inputs, directed scenarios plus random traffic against a queue-based frame model.
module tb_serial_frame_parity;

  logic clk = 1'b0;
  logic rst_n, dat, dat_en, sync;

  logic [2:0] f3;  logic p3, v3;  logic [1:0] i3;  logic [1:0] c3;
  logic [7:0] f8;  logic p8, v8;  logic [2:0] i8;  logic [7:0] c8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_frame_parity #(.FRAME_LEN(3), .ODD(1'b0), .CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .dat(dat), .dat_en(dat_en), .sync(sync),
    .frame_out(f3), .par_out(p3), .out_vld(v3), .bit_idx(i3), .frame_cnt(c3));

  serial_frame_parity #(.FRAME_LEN(8), .ODD(1'b1), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .dat(dat), .dat_en(dat_en), .sync(sync),
    .frame_out(f8), .par_out(p8), .out_vld(v8), .bit_idx(i8), .frame_cnt(c8));

  // Reference model: index 0 mirrors dut3, index 1 mirrors dut8.
  int          m_len [2] = '{3, 8};
  bit          m_odd [2] = '{1'b0, 1'b1};
  int          m_mod [2] = '{4, 256};
  bit          m_q   [2][$];
  logic [63:0] e_frame [2];
  logic        e_par [2];
  logic        e_vld [2];
  int          e_cnt [2];

  task automatic clk_in(input logic r, input logic d, input logic en, input logic s);
    int ones;
    rst_n = r; dat = d; dat_en = en; sync = s;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        m_q[k].delete();
        e_frame[k] = '0; e_par[k] = 1'b0; e_vld[k] = 1'b0; e_cnt[k] = 0;
      end else begin
        e_vld[k] = 1'b0;
        if (s) begin
          m_q[k].delete();
          if (en) m_q[k].push_back(d);
        end else if (en) begin
          m_q[k].push_back(d);
          if (m_q[k].size() == m_len[k]) begin
            e_frame[k] = '0;
            ones = 0;
            foreach (m_q[k][i]) begin
              e_frame[k] = e_frame[k] * 2 + 64'(m_q[k][i]);
              ones += int'(m_q[k][i]);
            end
            e_par[k] = ((ones % 2) == 1) ^ m_odd[k];
            e_vld[k] = 1'b1;
            e_cnt[k] = (e_cnt[k] + 1) % m_mod[k];
            m_q[k].delete();
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    clk_in(0, 0, 0, 0);
    clk_in(0, 1, 1, 0);
    checks++; if ({f3, p3, v3, i3, c3} !== 9'd0) begin errors++;
      $display("FAIL reset_dut3 got %h exp 0", {f3, p3, v3, i3, c3}); end
    checks++; if ({f8, p8, v8, i8, c8} !== 21'd0) begin errors++;
      $display("FAIL reset_dut8 got %h exp 0", {f8, p8, v8, i8, c8}); end
  endtask

  task automatic test_basic();
    clk_in(0, 0, 0, 0);
    clk_in(1, 1, 1, 0); clk_in(1, 0, 1, 0); clk_in(1, 1, 1, 0);
    checks++; if (f3 !== 3'b101) begin errors++; $display("FAIL basic_frame got %b exp 101", f3); end
    checks++; if (p3 !== 1'b0) begin errors++; $display("FAIL basic_par got %b exp 0", p3); end
    checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL basic_vld got %b exp 1", v3); end
    checks++; if (c3 !== 2'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", c3); end
    clk_in(1, 1, 1, 0);
    checks++; if (v3 !== 1'b0 || f3 !== 3'b101) begin errors++;
      $display("FAIL basic_hold got vld=%b frame=%b exp vld=0 frame=101", v3, f3); end
    clk_in(1, 1, 1, 0); clk_in(1, 1, 1, 0);
    checks++; if (f3 !== 3'b111 || p3 !== 1'b1 || c3 !== 2'd2) begin errors++;
      $display("FAIL basic_second got %b/%b/%0d exp 111/1/2", f3, p3, c3); end
  endtask

  task automatic test_odd8();
    logic [7:0] w;
    w = 8'h5A;
    for (int i = 7; i >= 0; i--) clk_in(1, w[i], 1, i == 7);
    checks++; if (f8 !== 8'h5A || p8 !== 1'b1 || v8 !== 1'b1) begin errors++;
      $display("FAIL odd8_5a got %h/%b/%b exp 5a/1/1", f8, p8, v8); end
    w = 8'h01;
    for (int i = 7; i >= 0; i--) clk_in(1, w[i], 1, 0);
    checks++; if (f8 !== 8'h01 || p8 !== 1'b0 || v8 !== 1'b1) begin errors++;
      $display("FAIL odd8_01 got %h/%b/%b exp 01/0/1", f8, p8, v8); end
  endtask

  task automatic test_gaps();
    logic [2:0] held;
    logic en_pat [6] = '{1, 0, 0, 1, 0, 1};
    logic d_pat  [6] = '{0, 1, 1, 1, 0, 1};
    clk_in(1, 0, 0, 1);
    held = f3;
    for (int i = 0; i < 6; i++) begin
      clk_in(1, en_pat[i] ? d_pat[i] : 1'($urandom_range(1)), en_pat[i], 0);
      if (i < 5) begin
        checks++; if (v3 !== 1'b0 || f3 !== held) begin errors++;
          $display("FAIL gaps_hold[%0d] got vld=%b frame=%b exp vld=0 frame=%b", i, v3, f3, held); end
      end
    end
    checks++; if (f3 !== 3'b011 || v3 !== 1'b1 || i3 !== 2'd0) begin errors++;
      $display("FAIL gaps_frame got %b/%b/%0d exp 011/1/0", f3, v3, i3); end
  endtask

  task automatic test_sync();
    logic [1:0] cb;
    clk_in(1, 0, 0, 1);
    clk_in(1, 0, 1, 0); clk_in(1, 1, 1, 0);
    cb = c3;
    clk_in(1, 1, 1, 1);
    checks++; if (v3 !== 1'b0 || i3 !== 2'd1 || c3 !== cb) begin errors++;
      $display("FAIL sync_edge got vld=%b idx=%0d cnt=%0d exp 0/1/%0d", v3, i3, c3, cb); end
    clk_in(1, 0, 1, 0); clk_in(1, 0, 1, 0);
    checks++; if (f3 !== 3'b100 || v3 !== 1'b1 || c3 !== 2'(cb + 2'd1)) begin errors++;
      $display("FAIL sync_frame got %b/%b/%0d exp 100/1/%0d", f3, v3, c3, 2'(cb + 2'd1)); end
  endtask

  task automatic test_reset_mid();
    clk_in(1, 0, 0, 1);
    clk_in(1, 1, 1, 0); clk_in(1, 0, 1, 0);
    clk_in(0, 1, 1, 0);
    checks++; if ({f3, p3, v3, i3, c3} !== 9'd0 || {f8, p8, v8, i8, c8} !== 21'd0) begin errors++;
      $display("FAIL midreset got %h %h exp 0 0", {f3, p3, v3, i3, c3}, {f8, p8, v8, i8, c8}); end
    clk_in(1, 1, 1, 0); clk_in(1, 1, 1, 0); clk_in(1, 0, 1, 0);
    checks++; if (f3 !== 3'b110 || p3 !== 1'b0 || v3 !== 1'b1) begin errors++;
      $display("FAIL midreset_frame got %b/%b/%b exp 110/0/1", f3, p3, v3); end
  endtask

  task automatic test_wrap();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic prev;
    clk_in(0, 0, 0, 0);
    prev = v3;
    for (int i = 0; i < 15; i++) begin
      clk_in(1, 1'($urandom_range(1)), 1, 0);
      checks++; if (prev && v3) begin errors++;
        $display("FAIL wrap_vld_consec at %0d got 1 exp 0", i); end
      prev = v3;
      if (i % 3 == 2) begin
        checks++; if (c3 !== seq[i/3]) begin errors++;
          $display("FAIL wrap_cnt[%0d] got %0d exp %0d", i / 3, c3, seq[i/3]); end
      end
    end
  endtask

  task automatic test_random();
    logic r, d, en, s, prev3, prev8;
    prev3 = v3; prev8 = v8;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(99) != 0);
      d  = 1'($urandom_range(1));
      en = ($urandom_range(9) < 8);
      s  = ($urandom_range(29) == 0);
      clk_in(r, d, en, s);
      checks++; if ({f3, p3, v3, i3, c3} !== {e_frame[0][2:0], e_par[0], e_vld[0], 2'(m_q[0].size()), 2'(e_cnt[0])}) begin
        errors++;
        $display("FAIL rand_dut3[%0d] got f=%b p=%b v=%b i=%0d c=%0d exp f=%b p=%b v=%b i=%0d c=%0d", i,
                 f3, p3, v3, i3, c3, e_frame[0][2:0], e_par[0], e_vld[0], m_q[0].size(), e_cnt[0]); end
      checks++; if ({f8, p8, v8, i8, c8} !== {e_frame[1][7:0], e_par[1], e_vld[1], 3'(m_q[1].size()), 8'(e_cnt[1])}) begin
        errors++;
        $display("FAIL rand_dut8[%0d] got f=%h p=%b v=%b i=%0d c=%0d exp f=%h p=%b v=%b i=%0d c=%0d", i,
                 f8, p8, v8, i8, c8, e_frame[1][7:0], e_par[1], e_vld[1], m_q[1].size(), e_cnt[1]); end
      checks++; if ((prev3 && v3) || (prev8 && v8)) begin errors++;
        $display("FAIL rand_vld_consec[%0d] got %b%b exp no repeat", i, v3, v8); end
      prev3 = v3; prev8 = v8;
    end
  endtask

  initial begin
    rst_n = 1'b0; dat = 1'b0; dat_en = 1'b0; sync = 1'b0;
    test_reset();
    test_basic();
    test_odd8();
    test_gaps();
    test_sync();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
